// File: rtl/seg7_pkg.sv
// Purpose : shared types and constants for the seven-segment BCD feeder path.
// Latency : n/a (declarations only).
// Backpressure: n/a (declarations only).
package seg7_pkg;

  // Number of display digits driven by the downstream seven-segment driver.
  localparam int SEG7_DIGITS = 4;

  // Value written when the binary input exceeds what four digits can show.
  localparam logic [15:0] BCD_SAT = 16'h9999;

  // Accumulator holds five BCD digits so the overflow digit can be observed.
  localparam int BCD_ACC_W = 20;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WRITE
  } seg7State_t;

endpackage

// File: rtl/bcd_adj_nibble.sv
// Purpose : double-dabble digit correction, adds 3 to a BCD digit that is >= 5.
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of its input.
// Ports   : iNib - BCD digit before the shift; oNib - corrected digit.
module bcd_adj_nibble (
  input  logic [3:0] iNib,
  output logic [3:0] oNib
);

  assign oNib = (iNib >= 4'd5) ? (iNib + 4'd3) : iNib;

endmodule

// File: rtl/seg7_bcd_feeder.sv
// Purpose : serial binary-to-BCD converter feeding the 4-digit seven-segment driver.
// Latency : oWR high in the cycle after edge E0+BIN_W for a load sampled at E0 in IDLE.
// Backpressure: none; a one-deep pending buffer holds loads arriving mid-conversion,
//               the newest value overwrites it and oDROP pulses on overwrite.
// Ports   : iCLK clock, iRST sync active-high reset, iBIN/iLOAD value and strobe,
//           oDIG/oWR packed BCD and write strobe to the driver, oOVF saturation flag,
//           oBUSY converter active, oDROP pending value lost.
module seg7_bcd_feeder
  import seg7_pkg::*;
#(
  parameter int BIN_W = 16
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic [BIN_W-1:0]         iBIN,
  input  logic                     iLOAD,
  output logic [SEG7_DIGITS*4-1:0] oDIG,
  output logic                     oWR,
  output logic                     oOVF,
  output logic                     oBUSY,
  output logic                     oDROP
);

  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
  localparam int DIG_W = SEG7_DIGITS * 4;
  localparam int NIB_N = BCD_ACC_W / 4;

  seg7State_t state, stateNext;

  logic [BCD_ACC_W-1:0] accReg, accNext, accAdj, accShift;
  logic [BIN_W-1:0]     binReg, binNext, binShift, startVal;
  logic [CNT_W-1:0]     cnt, cntNext;
  logic [BIN_W-1:0]     pendReg, pendNext;
  logic                 pendValid, pendValidNext;
  logic [DIG_W-1:0]     digNext;
  logic                 ovfNext, wrNext, dropNext, busyNext, startReq;

  // Correct every digit before the shift so the doubled value stays valid BCD.
  for (genvar n = 0; n < NIB_N; n++) begin : gAdj
    bcd_adj_nibble uAdj (
      .iNib(accReg[n*4 +: 4]),
      .oNib(accAdj[n*4 +: 4])
    );
  end

  // The binary MSB moves into the accumulator LSB on every shift.
  assign {accShift, binShift} = {accAdj, binReg} << 1;

  always_comb begin
    stateNext     = state;
    accNext       = accReg;
    binNext       = binReg;
    cntNext       = cnt;
    pendNext      = pendReg;
    pendValidNext = pendValid;
    digNext       = oDIG;
    ovfNext       = oOVF;
    wrNext        = 1'b0;
    dropNext      = 1'b0;
    startReq      = 1'b0;
    startVal      = iBIN;

    case (state)
      IDLE: begin
        if (iLOAD) startReq = 1'b1;
      end

      SHIFT: begin
        accNext = accShift;
        binNext = binShift;
        cntNext = cnt + CNT_W'(1);
        // The running conversion is untouched; new loads only go to pending.
        if (iLOAD) begin
          pendNext      = iBIN;
          pendValidNext = 1'b1;
          dropNext      = pendValid;
        end
        if (cnt == CNT_LAST) begin
          stateNext = WRITE;
          wrNext    = 1'b1;
          if (accShift[BCD_ACC_W-1:DIG_W] != '0) begin
            digNext = BCD_SAT;
            ovfNext = 1'b1;
          end else begin
            digNext = accShift[DIG_W-1:0];
            ovfNext = 1'b0;
          end
        end
      end

      WRITE: begin
        // A load in this cycle is newer than anything pending, so it wins.
        if (iLOAD) begin
          startReq      = 1'b1;
          pendValidNext = 1'b0;
        end else if (pendValid) begin
          startReq      = 1'b1;
          startVal      = pendReg;
          pendValidNext = 1'b0;
        end else begin
          stateNext = IDLE;
        end
      end

      default: stateNext = IDLE;
    endcase

    if (startReq) begin
      accNext   = '0;
      binNext   = startVal;
      cntNext   = '0;
      stateNext = SHIFT;
    end

    busyNext = (stateNext != IDLE);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= IDLE;
      accReg    <= '0;
      binReg    <= '0;
      cnt       <= '0;
      pendReg   <= '0;
      pendValid <= 1'b0;
      oDIG      <= '0;
      oWR       <= 1'b0;
      oOVF      <= 1'b0;
      oBUSY     <= 1'b0;
      oDROP     <= 1'b0;
    end else begin
      state     <= stateNext;
      accReg    <= accNext;
      binReg    <= binNext;
      cnt       <= cntNext;
      pendReg   <= pendNext;
      pendValid <= pendValidNext;
      oDIG      <= digNext;
      oWR       <= wrNext;
      oOVF      <= ovfNext;
      oBUSY     <= busyNext;
      oDROP     <= dropNext;
    end
  end

endmodule

// File: tb/tb_seg7_bcd_feeder.sv
// Purpose : scoreboard bench for seg7_bcd_feeder using directed load sequences.
// Latency : checks load-to-write latency and write-to-write spacing.
// Backpressure: exercises pending overwrite, load during WRITE and reset mid-conversion.
module tb_seg7_bcd_feeder;

  localparam int BIN_W = 16;

  logic             iCLK = 1'b0;
  logic             iRST;
  logic [BIN_W-1:0] iBIN;
  logic             iLOAD;
  logic [15:0]      oDIG;
  logic             oWR, oOVF, oBUSY, oDROP;

  seg7_bcd_feeder #(.BIN_W(BIN_W)) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .iBIN (iBIN),
    .iLOAD(iLOAD),
    .oDIG (oDIG),
    .oWR  (oWR),
    .oOVF (oOVF),
    .oBUSY(oBUSY),
    .oDROP(oDROP)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic [15:0] dig;
    logic        ovf;
  } expWr_t;

  expWr_t sbQ[$];

  int   nVec = 0;
  int   nMiss = 0;
  int   cyc = 0;
  int   wrCount = 0;
  int   dropCount = 0;
  int   busyLow = 0;
  int   wrLastCyc = 0;
  int   wrPrevCyc = 0;
  int   loadCyc = 0;
  int   wrBase = 0;
  int   dropBase = 0;
  logic prevWr = 1'b0;
  logic seen100 = 1'b0;
  logic watchBusy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic o);
    expWr_t e;
    e.dig = d;
    e.ovf = o;
    sbQ.push_back(e);
  endtask

  // Drives a one-cycle load; loadCyc is the cycle number of the sampling edge.
  task automatic load(input logic [BIN_W-1:0] v);
    @(posedge iCLK);
    #1;
    iBIN  = v;
    iLOAD = 1'b1;
    @(posedge iCLK);
    #1;
    iLOAD   = 1'b0;
    loadCyc = cyc;
  endtask

  task automatic waitWr(input int target, input string name);
    for (int i = 0; i < 60; i++) begin
      if (wrCount >= target) break;
      @(negedge iCLK);
      #2;
    end
    check(name, 32'(wrCount >= target), 32'd1);
  endtask

  initial begin
    forever begin
      @(posedge iCLK);
      cyc++;
    end
  end

  // Monitor: pops the scoreboard on every write strobe.
  initial begin
    expWr_t e;
    forever begin
      @(negedge iCLK);
      if (watchBusy && !oBUSY) busyLow++;
      if (oDROP === 1'b1) dropCount++;
      if (oWR === 1'b1) begin
        wrCount++;
        wrPrevCyc = wrLastCyc;
        wrLastCyc = cyc;
        check("wrWidth", 32'(prevWr), 32'd0);
        if (oDIG == 16'h0100) seen100 = 1'b1;
        if (sbQ.size() == 0) begin
          nVec++;
          nMiss++;
          $display("FAIL unexpectedWr: got dig=%h ovf=%b, expected no write", oDIG, oOVF);
        end else begin
          e = sbQ.pop_front();
          check("wrDig", 32'(oDIG), 32'(e.dig));
          check("wrOvf", 32'(oOVF), 32'(e.ovf));
        end
      end
      prevWr = oWR;
    end
  end

  initial begin
    #100000;
    $display("FAIL globalTimeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    // Reset, with a load held alongside it that must be ignored.
    iRST  = 1'b1;
    iLOAD = 1'b1;
    iBIN  = 16'd55;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    check("rstDig", 32'(oDIG), 32'h0);
    check("rstWr", 32'(oWR), 32'd0);
    check("rstOvf", 32'(oOVF), 32'd0);
    check("rstBusy", 32'(oBUSY), 32'd0);
    check("rstDrop", 32'(oDROP), 32'd0);
    @(posedge iCLK);
    #1;
    iRST  = 1'b0;
    iLOAD = 1'b0;
    @(negedge iCLK);
    check("rstLoadIgnored", 32'(oBUSY), 32'd0);

    // Plain conversion with latency and busy timing.
    push(16'h1234, 1'b0);
    load(16'd1234);
    @(negedge iCLK);
    check("busyRise", 32'(oBUSY), 32'd1);
    waitWr(1, "wr1234");
    check("latency", 32'(wrLastCyc - loadCyc), 32'd16);
    @(negedge iCLK);
    check("busyFall", 32'(oBUSY), 32'd0);

    // Boundaries of the displayable range.
    push(16'h0000, 1'b0);
    load(16'd0);
    waitWr(2, "wr0");
    push(16'h9999, 1'b0);
    load(16'd9999);
    waitWr(3, "wr9999");

    // Saturation; output holds between writes.
    push(16'h9999, 1'b1);
    load(16'd10000);
    waitWr(4, "wr10000");
    push(16'h9999, 1'b1);
    load(16'd65535);
    repeat (8) @(negedge iCLK);
    check("holdDig", 32'(oDIG), 32'h9999);
    check("holdOvf", 32'(oOVF), 32'd1);
    waitWr(5, "wr65535");

    // Two loads during SHIFT: the second overwrites the first pending value.
    dropBase = dropCount;
    push(16'h0042, 1'b0);
    push(16'h0007, 1'b0);
    load(16'd42);
    load(16'd100);
    load(16'd7);
    waitWr(7, "wr7");
    check("spacingPend", 32'(wrLastCyc - wrPrevCyc), 32'd17);
    check("dropOnce", 32'(dropCount - dropBase), 32'd1);
    check("no100", 32'(seen100), 32'd0);

    // Reset on the 8th SHIFT cycle, with a value pending.
    load(16'd5678);
    load(16'd33);
    repeat (5) @(posedge iCLK);
    #1;
    iRST = 1'b1;
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
    @(negedge iCLK);
    check("midRstDig", 32'(oDIG), 32'h0);
    check("midRstBusy", 32'(oBUSY), 32'd0);
    check("midRstOvf", 32'(oOVF), 32'd0);
    check("midRstWr", 32'(oWR), 32'd0);
    wrBase = wrCount;
    repeat (40) @(negedge iCLK);
    check("noWrAfterRst", 32'(wrCount), 32'(wrBase));

    // Load during the WRITE cycle starts a new conversion back to back.
    push(16'h0001, 1'b0);
    push(16'h0002, 1'b0);
    wrBase = wrCount;
    load(16'd1);
    busyLow   = 0;
    watchBusy = 1'b1;
    repeat (16) @(posedge iCLK);
    #1;
    iBIN  = 16'd2;
    iLOAD = 1'b1;
    @(posedge iCLK);
    #1;
    iLOAD = 1'b0;
    waitWr(wrBase + 2, "wr2");
    watchBusy = 1'b0;
    check("busyStaysHigh", 32'(busyLow), 32'd0);
    check("spacingWrite", 32'(wrLastCyc - wrPrevCyc), 32'd17);

    repeat (3) @(negedge iCLK);
    check("sbEmpty", 32'(sbQ.size()), 32'd0);
    check("dropTotal", 32'(dropCount), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule

// File: doc/seg7_bcd_feeder.md
# seg7_bcd_feeder

Sequential binary-to-BCD converter that sits directly upstream of the four-digit seven-segment driver. It accepts a binary value with a load strobe and converts it by shift-and-add-3 (double dabble), one bit per clock. It delivers the packed 4-digit BCD word on the driver's `iDIG`/`iWR` write interface. Values above 9999 saturate to 9999 and raise an overflow flag. A one-deep pending buffer absorbs loads that arrive mid-conversion.

## Interface

Parameters:
- `BIN_W`, default 16: binary input width; legal range 4..16.

Ports (one clock; reset is synchronous and active-high):
- `iCLK` in, 1: clock; all logic on the rising edge.
- `iRST` in, 1: synchronous active-high reset.
- `iBIN` in, BIN_W: unsigned binary value to display.
- `iLOAD` in, 1: single-cycle strobe that requests conversion of `iBIN`.
- `oDIG` out, 16: packed BCD, digit 3 in [15:12] … digit 0 in [3:0]; connects to driver `iDIG`.
- `oWR` out, 1: one-cycle write strobe when `oDIG` updates; connects to driver `iWR`.
- `oOVF` out, 1: the last written value exceeded 9999; updates with `oWR`.
- `oBUSY` out, 1: high whenever the state is not IDLE.
- `oDROP` out, 1: one-cycle pulse when a pending value is overwritten before it is converted.

## Operation

- State machine has three states: IDLE, SHIFT, WRITE.
- Working registers:
  - 20-bit BCD accumulator (5 digits).
  - BIN_W-bit binary shift register.
  - Iteration counter, `$clog2(BIN_W)` bits.
  - Pending value register plus a valid bit.
- Start action: accumulator <= 0, binary shift register <= source value, counter <= 0, state <= SHIFT.
- IDLE:
  - On `iLOAD`, perform the start action with `iBIN`.
  - Otherwise hold.
- SHIFT, each cycle:
  - Add 3 to every accumulator nibble that is ≥5.
  - Shift {accumulator, binary register} left by 1.
  - Increment the counter.
  - On the cycle where counter == BIN_W-1, capture the result and go to WRITE.
- Result capture:
  - If digit 4 ≠ 0: `oDIG` <= 16'h9999 and `oOVF` <= 1.
  - Else: `oDIG` <= accumulator[15:0] and `oOVF` <= 0.
  - `oWR` <= 1.
- WRITE (one cycle; `oWR` is high during this cycle):
  - If `iLOAD`: start with `iBIN` and clear the pending valid bit; the fresh value wins.
  - Else if pending valid: start with the pending value and clear the valid bit.
  - Else go to IDLE.
- `iLOAD` during SHIFT:
  - pending <= `iBIN`, valid <= 1; the latest value wins.
  - If valid was already 1, pulse `oDROP`.
- The conversion in progress is never disturbed by a new load.
- `oDIG` and `oOVF` hold their values between writes.

## Timing

- Reset values: state IDLE, `oDIG`=16'h0000, `oWR`=0, `oOVF`=0, `oBUSY`=0, `oDROP`=0, pending valid 0.
- Latency: `iLOAD` sampled at edge E0 in IDLE → `oWR` high in the cycle after edge E0+BIN_W (16 cycles for the default).
- `oWR` is always exactly one cycle wide.
- Minimum spacing between `oWR` pulses is BIN_W+1 cycles.
- `oBUSY` rises the cycle after the sampling edge and falls the cycle after WRITE when no work is queued.
- `iRST` mid-conversion:
  - Next cycle all outputs are at reset values.
  - No `oWR` is produced and the pending value is discarded.
- `iRST` and `iLOAD` in the same cycle: reset wins and the load is ignored.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure

- Shared package `seg7_pkg`:
  - State enum (IDLE, SHIFT, WRITE).
  - `SEG7_DIGITS`=4.
  - `BCD_SAT`=16'h9999.
  - `BCD_ACC_W`=20.
- Sub-module `bcd_adj_nibble`: combinational, 4-bit in/out, outputs the input +3 when ≥5. Instantiated 5× in a generate loop.
- Top level holds the FSM, datapath, pending buffer and output registers.

## Test plan

- Reset; load 1234 → after 16 cycles a single `oWR` pulse, `oDIG`=16'h1234, `oOVF`=0, then `oBUSY` drops.
- Load 0, then 9999 → `oDIG`=16'h0000 and then 16'h9999, `oOVF`=0 both times.
- Load 10000, then 65535 → `oDIG`=16'h9999, `oOVF`=1 both times; `oDIG` unchanged between them.
- Load 42; during SHIFT load 100, then 7 → `oDROP` pulses once; `oWR` produces 0x0042, then 0x0007 exactly 17 cycles later; 0x0100 never appears.
- Load 5678; assert `iRST` on the 8th SHIFT cycle → no `oWR`; next cycle `oDIG`=0, `oBUSY`=0, `oOVF`=0.
- Load 1; assert `iLOAD` with 2 during the WRITE cycle → `oWR` with 0x0001, then `oWR` with 0x0002 exactly 17 cycles later; `oBUSY` stays high throughout.
